uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, giving fpga_clk cycles per bit period (even, at least 8).
REQ-002 The block SHALL have port fpga_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port nrst, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port sin, input, 1, asynchronous serial line, idle high.
REQ-005 The block SHALL have port dout, output, 8, last correctly received byte.
REQ-006 The block SHALL have port dout_valid, output, 1, one-cycle pulse when dout updates.
REQ-007 The block SHALL have port frame_err, output, 1, one-cycle pulse on bad stop bit.
REQ-008 The block SHALL have port parity_err, output, 1, one-cycle pulse on parity mismatch.
REQ-009 The block SHALL have port busy, output, 1, high in every state other than IDLE.

Function
REQ-010 sin SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value (2-cycle latency).
REQ-011 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, with one bit counter (0..7) and one tick counter (0..CLKS_PER_BIT-1).
REQ-012 IDLE SHALL go to START only on a synchronized 1->0 transition, clearing the tick counter; a line held low never re-arms.
REQ-013 START SHALL sample at tick CLKS_PER_BIT/2-1: a 0 goes to DATA; a 1 is a glitch and returns to IDLE with no output pulse.
REQ-014 DATA, PARITY and STOP SHALL sample once every CLKS_PER_BIT ticks after the START sample point, at bit centre.
REQ-015 DATA bits SHALL be taken LSB first; after bit 7 the next state is PARITY when compiled in, else STOP.
REQ-016 At the STOP sample a 1 SHALL load dout and pulse dout_valid the next cycle; a 0 SHALL pulse frame_err and leave dout unchanged.
REQ-017 On a parity mismatch, STOP SHALL pulse parity_err and suppress dout_valid; if framing also fails, both error pulses assert together.
REQ-018 STOP SHALL return to IDLE on the cycle after its sample; a new start edge is then accepted immediately.
REQ-019 dout SHALL hold its value until the next good frame; there is no consumer handshake and an unread byte is overwritten.

Reset
REQ-020 With nrst low, state SHALL be IDLE, dout 8'h00, dout_valid/frame_err/parity_err/busy 0, both synchronizer flops 1, counters 0.
REQ-021 Reset asserted mid-frame SHALL abort the frame with no pulse; after release the block waits for a fresh 1->0 edge.

Configuration
REQ-022 Macro UART_RX_PARITY_EN defined SHALL enable the PARITY state, checking one even-parity bit between bit 7 and stop (8E1).
REQ-023 Without UART_RX_PARITY_EN the frame SHALL be 8N1, PARITY is unreachable, and parity_err is tied 0.

Structure
REQ-024 Package uart_pkg SHALL hold the rx state enum type, DATA_BITS=8, and the default CLKS_PER_BIT shared with uart_tx.
REQ-025 Sub-module uart_sync2 (2-flop synchronizer, reset value 1) SHALL be instantiated for sin; the rest is flat.

Verification
REQ-026 8N1 frame 0xA5 at 16 clks/bit -> dout=0xA5, one dout_valid pulse, busy high for the frame duration.
REQ-027 2-cycle low glitch on sin -> START rejects it; no pulse, back in IDLE, busy low.
REQ-028 Frame 0x3C with stop bit 0 -> frame_err pulse, dout keeps previous 0xA5; a following 0x55 frame is received correctly.
REQ-029 Back-to-back frames 0x00 then 0xFF with no idle gap -> two dout_valid pulses, values in order.
REQ-030 UART_RX_PARITY_EN, 0x07 with parity bit 0 -> parity_err pulse, no dout_valid; 0x07 with parity bit 1 -> dout_valid, dout=0x07.
REQ-031 nrst pulsed low during DATA bit 4 -> outputs at reset values, no pulse; the next full frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: rx state encoding, frame geometry and default bit timing.
package uart_pkg;

    localparam int unsigned DATA_BITS            = 8;
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous line that idles high.
module uart_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
// Samples at bit centre derived from the start-bit falling edge.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                 fpga_clk,
    input  logic                 nrst,
    input  logic                 sin,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int unsigned TICK_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS);
    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    rx_state_t            state;
    logic                 sin_s;
    logic                 sin_d;
    logic [TICK_W-1:0]    tick;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 tick_end;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad;
`endif

    uart_sync2 u_sync (
        .clk   (fpga_clk),
        .rst_n (nrst),
        .d     (sin),
        .q     (sin_s)
    );

    assign tick_end = (tick == FULL_LAST);

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge fpga_clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            sin_d      <= 1'b1;
            tick       <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            sin_d      <= sin_s;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // only a genuine high-to-low edge arms the receiver
                    if (sin_d && !sin_s) begin
                        state <= START;
                        tick  <= '0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (tick == HALF_LAST) begin
                        tick <= '0;
                        if (!sin_s) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                end
                DATA: begin
                    if (tick_end) begin
                        tick  <= '0;
                        shreg <= {sin_s, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick_end) begin
                        tick    <= '0;
                        par_bad <= (^shreg) ^ sin_s;
                        state   <= STOP;
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (tick_end) begin
                        tick      <= '0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                        frame_err <= !sin_s;
`ifdef UART_RX_PARITY_EN
                        parity_err <= par_bad;
                        if (sin_s && !par_bad) begin
`else
                        if (sin_s) begin
`endif
                            dout       <= shreg;
                            dout_valid <= 1'b1;
                        end
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tick  <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame table plus glitch, back-to-back and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int unsigned CPB = 16;

    typedef struct {
        logic [7:0] data;
        logic       par_flip;
        logic       stop;
        int         exp_valid;
        int         exp_ferr;
        int         exp_perr;
        logic [7:0] exp_dout;
    } vec_t;

    logic       fpga_clk = 1'b0;
    logic       nrst     = 1'b0;
    logic       sin      = 1'b1;
    logic [7:0] dout;
    logic       dout_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int total     = 0;
    int bad       = 0;
    int n_valid   = 0;
    int n_ferr    = 0;
    int n_perr    = 0;
    int busy_miss = 0;
    logic [7:0] rx_q[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .fpga_clk   (fpga_clk),
        .nrst       (nrst),
        .sin        (sin),
        .dout       (dout),
        .dout_valid (dout_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 fpga_clk = ~fpga_clk;

    // Pulse monitor, sampled on the inactive edge
    always @(negedge fpga_clk) begin
        if (dout_valid === 1'b1) begin
            n_valid++;
            rx_q.push_back(dout);
        end
        if (frame_err === 1'b1)  n_ferr++;
        if (parity_err === 1'b1) n_perr++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        sin = b;
        repeat (CPB / 2) @(negedge fpga_clk);
        if (busy !== 1'b1) busy_miss++;
        repeat (CPB - CPB / 2) @(negedge fpga_clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`endif
        send_bit(stop);
    endtask

    task automatic idle(input int bits);
        sin = 1'b1;
        repeat (bits * CPB) @(negedge fpga_clk);
    endtask

    initial begin
        vec_t vecs[$];
        int v0, f0, p0, qs;
        logic [7:0] d;

        vecs.push_back('{8'hA5, 1'b0, 1'b1, 1, 0, 0, 8'hA5});
        vecs.push_back('{8'h3C, 1'b0, 1'b0, 0, 1, 0, 8'hA5});
        vecs.push_back('{8'h55, 1'b0, 1'b1, 1, 0, 0, 8'h55});
        vecs.push_back('{8'h80, 1'b0, 1'b1, 1, 0, 0, 8'h80});
        vecs.push_back('{8'h01, 1'b0, 1'b1, 1, 0, 0, 8'h01});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{8'h07, 1'b1, 1'b1, 0, 0, 1, 8'h01});
        vecs.push_back('{8'h07, 1'b0, 1'b1, 1, 0, 0, 8'h07});
        vecs.push_back('{8'hE3, 1'b1, 1'b0, 0, 1, 1, 8'h07});
`endif

        // Reset state
        repeat (5) @(negedge fpga_clk);
        check("reset dout", 32'(dout), 32'h00);
        check("reset dout_valid", 32'(dout_valid), 32'h0);
        check("reset frame_err", 32'(frame_err), 32'h0);
        check("reset parity_err", 32'(parity_err), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        nrst = 1'b1;
        idle(2);

        for (int i = 0; i < vecs.size(); i++) begin
            v0 = n_valid; f0 = n_ferr; p0 = n_perr; busy_miss = 0;
            send_frame(vecs[i].data, vecs[i].par_flip, vecs[i].stop);
            idle(2);
            check($sformatf("vec%0d valid_cnt", i), 32'(n_valid - v0), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d ferr_cnt", i), 32'(n_ferr - f0), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d perr_cnt", i), 32'(n_perr - p0), 32'(vecs[i].exp_perr));
            check($sformatf("vec%0d dout", i), 32'(dout), 32'(vecs[i].exp_dout));
            check($sformatf("vec%0d busy_in_frame", i), 32'(busy_miss), 32'h0);
            check($sformatf("vec%0d busy_after", i), 32'(busy), 32'h0);
        end

        // Short low glitch: armed, then rejected at the start sample
        v0 = n_valid; f0 = n_ferr; p0 = n_perr;
        sin = 1'b0;
        repeat (2) @(negedge fpga_clk);
        sin = 1'b1;
        repeat (4) @(negedge fpga_clk);
        check("glitch busy_armed", 32'(busy), 32'h1);
        idle(2);
        check("glitch busy_after", 32'(busy), 32'h0);
        check("glitch pulses", 32'((n_valid - v0) + (n_ferr - f0) + (n_perr - p0)), 32'h0);

        // Back-to-back frames with no idle gap
        v0 = n_valid; qs = rx_q.size();
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        idle(2);
        check("b2b valid_cnt", 32'(n_valid - v0), 32'h2);
        check("b2b first", (rx_q.size() > qs) ? 32'(rx_q[qs]) : 32'hDEAD, 32'h00);
        check("b2b second", (rx_q.size() > qs + 1) ? 32'(rx_q[qs+1]) : 32'hDEAD, 32'hFF);

        // Reset asserted in data bit 4
        v0 = n_valid; f0 = n_ferr; p0 = n_perr;
        d = 8'hF0;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        sin = 1'b1;
        repeat (4) @(negedge fpga_clk);
        nrst = 1'b0;
        repeat (3) @(negedge fpga_clk);
        check("midrst dout", 32'(dout), 32'h00);
        check("midrst busy", 32'(busy), 32'h0);
        nrst = 1'b1;
        idle(3);
        check("midrst busy_after", 32'(busy), 32'h0);
        check("midrst pulses", 32'((n_valid - v0) + (n_ferr - f0) + (n_perr - p0)), 32'h0);
        check("midrst dout_after", 32'(dout), 32'h00);
        send_frame(8'h81, 1'b0, 1'b1);
        idle(2);
        check("post_rst valid_cnt", 32'(n_valid - v0), 32'h1);
        check("post_rst dout", 32'(dout), 32'h81);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
